// File: rtl/vga_timing_gen.sv
// VGA raster timing generator for the bouncing-squares display.
// Produces the raster counters, the sync pulses and the display window,
// plus single-cycle line/frame/vblank strobes in the clk domain.
// Every output is registered and decoded from the next counter values,
// so the flags always describe the hpos/vpos presented in the same cycle.
module vga_timing_gen #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic       vblank_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // The counters are 10 bits wide; larger rasters cannot be represented.
    generate
        if (H_TOTAL > 1024) begin : g_h_total_too_big
            $error("vga_timing_gen: H_TOTAL exceeds 1024");
        end
        if (V_TOTAL > 1024) begin : g_v_total_too_big
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
    endgenerate

    // Comparison limits are held one bit wider than the counters so that an
    // end bound of exactly 1024 still compares correctly as unsigned.
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  VBLANK_ROW = 10'(V_DISPLAY);
    localparam logic [10:0] H_DISP_END = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP_END = 11'(V_DISPLAY);
    localparam logic [10:0] HS_BEGIN   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEGIN   = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    // Asserted and idle levels of both sync outputs.
    localparam logic SYNC_ON  = !SYNC_ACTIVE_LOW;
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       hs_active;
    logic       vs_active;
    logic       de_next;
    logic       line_next;
    logic       frame_next;
    logic       vblank_next;

    // Next raster position: advance one pixel per enabled cycle, wrap at the
    // end of the line and carry into the line counter, wrap at end of frame.
    always_comb begin
        h_next = hpos;
        v_next = vpos;
        if (pix_en) begin
            if (hpos == H_LAST) begin
                h_next = '0;
                if (vpos == V_LAST) begin
                    v_next = '0;
                end else begin
                    v_next = vpos + 10'd1;
                end
            end else begin
                h_next = hpos + 10'd1;
            end
        end
    end

    // Decode all flags from the next position; strobes need an actual
    // advance, so they stay low on held cycles and never fire out of reset.
    always_comb begin
        hs_active   = ({1'b0, h_next} >= HS_BEGIN) && ({1'b0, h_next} < HS_END);
        vs_active   = ({1'b0, v_next} >= VS_BEGIN) && ({1'b0, v_next} < VS_END);
        de_next     = ({1'b0, h_next} < H_DISP_END) && ({1'b0, v_next} < V_DISP_END);
        line_next   = pix_en && (h_next == 10'd0);
        frame_next  = line_next && (v_next == 10'd0);
        vblank_next = line_next && (v_next == VBLANK_ROW);
    end

    // Output registers; reset returns to the top-left idle state silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos         <= '0;
            vpos         <= '0;
            hsync        <= SYNC_OFF;
            vsync        <= SYNC_OFF;
            display_on   <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            hpos         <= h_next;
            vpos         <= v_next;
            hsync        <= hs_active ? SYNC_ON : SYNC_OFF;
            vsync        <= vs_active ? SYNC_ON : SYNC_OFF;
            display_on   <= de_next;
            line_start   <= line_next;
            frame_start  <= frame_next;
            vblank_start <= vblank_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// Three instances share clk/rst_n/pix_en: default timing, default timing with
// active-high syncs, and a tiny raster (15x13) so whole frames fit in a short run.
// Every cycle each instance is compared with a position derived from the number
// of enabled cycles since reset; directed checks add hand-computed counts.
module tb_vga_timing_gen;

    // Tiny raster: H 8+2+3+2 = 15, hsync at 10..12; V 6+2+2+3 = 13, vsync at 8..9.
    localparam int S_HD = 8;
    localparam int S_HF = 2;
    localparam int S_HS = 3;
    localparam int S_HB = 2;
    localparam int S_VD = 6;
    localparam int S_VF = 2;
    localparam int S_VS = 2;
    localparam int S_VB = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic pix_en;

    logic [9:0] hpos_d, vpos_d, hpos_p, vpos_p, hpos_s, vpos_s;
    logic hsync_d, vsync_d, display_on_d, line_start_d, frame_start_d, vblank_start_d;
    logic hsync_p, vsync_p, display_on_p, line_start_p, frame_start_p, vblank_start_p;
    logic hsync_s, vsync_s, display_on_s, line_start_s, frame_start_s, vblank_start_s;

    logic [25:0] pack_d, pack_p, pack_s;

    int  vec_count  = 0;
    int  miss_count = 0;
    int  t_def      = 0;
    int  t_small    = 0;
    bit  adv        = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_default (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hpos(hpos_d), .vpos(vpos_d), .hsync(hsync_d), .vsync(vsync_d),
        .display_on(display_on_d), .line_start(line_start_d),
        .frame_start(frame_start_d), .vblank_start(vblank_start_d)
    );

    vga_timing_gen #(.SYNC_ACTIVE_LOW(1'b0)) u_dut_pol (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hpos(hpos_p), .vpos(vpos_p), .hsync(hsync_p), .vsync(vsync_p),
        .display_on(display_on_p), .line_start(line_start_p),
        .frame_start(frame_start_p), .vblank_start(vblank_start_p)
    );

    vga_timing_gen #(
        .H_DISPLAY(S_HD), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_DISPLAY(S_VD), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_dut_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hpos(hpos_s), .vpos(vpos_s), .hsync(hsync_s), .vsync(vsync_s),
        .display_on(display_on_s), .line_start(line_start_s),
        .frame_start(frame_start_s), .vblank_start(vblank_start_s)
    );

    assign pack_d = {hpos_d, vpos_d, hsync_d, vsync_d, display_on_d,
                     line_start_d, frame_start_d, vblank_start_d};
    assign pack_p = {hpos_p, vpos_p, hsync_p, vsync_p, display_on_p,
                     line_start_p, frame_start_p, vblank_start_p};
    assign pack_s = {hpos_s, vpos_s, hsync_s, vsync_s, display_on_s,
                     line_start_s, frame_start_s, vblank_start_s};

    // Expected output word for a raster after t enabled cycles since reset.
    function automatic logic [25:0] expectVec(input int t,
            input int hd, input int hf, input int hsw, input int hb,
            input int vd, input int vf, input int vsw, input int vbk,
            input bit sal, input bit adv_in);
        int ht, vt, h, v;
        bit hs_on, vs_on, de, ls, fs, vb;
        logic [9:0] h10, v10;
        ht    = hd + hf + hsw + hb;
        vt    = vd + vf + vsw + vbk;
        h     = t % ht;
        v     = (t / ht) % vt;
        hs_on = (h >= hd + hf) && (h < hd + hf + hsw);
        vs_on = (v >= vd + vf) && (v < vd + vf + vsw);
        de    = (h < hd) && (v < vd);
        ls    = adv_in && (h == 0);
        fs    = ls && (v == 0);
        vb    = ls && (v == vd);
        h10   = 10'(h);
        v10   = 10'(v);
        return {h10, v10, hs_on ? ~sal : sal, vs_on ? ~sal : sal, de, ls, fs, vb};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle, then compare every instance against the position model.
    task automatic applyStimulus(input logic rst_val, input logic pix_val);
        rst_n  = rst_val;
        pix_en = pix_val;
        @(posedge clk);
        #1;
        if (!rst_val) begin
            t_def   = 0;
            t_small = 0;
            adv     = 1'b0;
        end else if (pix_val) begin
            t_def++;
            t_small++;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
        checkOutput("default_vec", 32'(pack_d),
                    32'(expectVec(t_def, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, adv)));
        checkOutput("pol_vec", 32'(pack_p),
                    32'(expectVec(t_def, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, adv)));
        checkOutput("small_vec", 32'(pack_s),
                    32'(expectVec(t_small, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB,
                                  1'b1, adv)));
    endtask

    initial begin
        int ls_count, fs_count;
        int hs_low, hs_min, hs_max, hp_high, hp_min, hp_max;
        int first_ls, second_ls, doubles;
        bit prev_ls;
        int fs1, fs2, vb1, vb2, vs_low, de_count;

        rst_n  = 1'b0;
        pix_en = 1'b0;

        $display("[TB] reset state");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("rst_hpos", 32'(hpos_d), 32'd0);
        checkOutput("rst_vpos", 32'(vpos_d), 32'd0);
        checkOutput("rst_display_on", 32'(display_on_d), 32'd1);
        checkOutput("rst_syncs_low_pol", 32'({hsync_d, vsync_d}), 32'b11);
        checkOutput("rst_syncs_high_pol", 32'({hsync_p, vsync_p}), 32'b00);
        checkOutput("rst_strobes", 32'({line_start_d, frame_start_d, vblank_start_d}), 32'd0);

        $display("[TB] one full line");
        ls_count = 0;
        fs_count = 0;
        for (int i = 1; i <= 800; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (line_start_d) ls_count++;
            if (frame_start_d) fs_count++;
            if (i == 799) checkOutput("line_end_hpos", 32'(hpos_d), 32'd799);
        end
        checkOutput("wrap_hpos", 32'(hpos_d), 32'd0);
        checkOutput("wrap_vpos", 32'(vpos_d), 32'd1);
        checkOutput("wrap_line_start", 32'(line_start_d), 32'd1);
        checkOutput("line_start_count", 32'(ls_count), 32'd1);
        checkOutput("frame_start_count", 32'(fs_count), 32'd0);

        $display("[TB] hsync over three lines, both polarities");
        hs_low = 0;  hs_min = 9999; hs_max = -1;
        hp_high = 0; hp_min = 9999; hp_max = -1;
        for (int i = 0; i < 2400; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (!hsync_d) begin
                hs_low++;
                if (int'(hpos_d) < hs_min) hs_min = int'(hpos_d);
                if (int'(hpos_d) > hs_max) hs_max = int'(hpos_d);
            end
            if (hsync_p) begin
                hp_high++;
                if (int'(hpos_p) < hp_min) hp_min = int'(hpos_p);
                if (int'(hpos_p) > hp_max) hp_max = int'(hpos_p);
            end
        end
        checkOutput("hsync_low_count", 32'(hs_low), 32'd288);
        checkOutput("hsync_low_min", 32'(hs_min), 32'd656);
        checkOutput("hsync_low_max", 32'(hs_max), 32'd751);
        checkOutput("hsync_pol_high_count", 32'(hp_high), 32'd288);
        checkOutput("hsync_pol_min", 32'(hp_min), 32'd656);
        checkOutput("hsync_pol_max", 32'(hp_max), 32'd751);

        $display("[TB] pix_en toggling");
        first_ls  = -1;
        second_ls = -1;
        doubles   = 0;
        prev_ls   = line_start_d;
        for (int i = 1; i <= 3300; i++) begin
            applyStimulus(1'b1, (i % 2) == 1);
            if (line_start_d) begin
                if (prev_ls) doubles++;
                if (first_ls < 0) first_ls = i;
                else if (second_ls < 0) second_ls = i;
            end
            prev_ls = line_start_d;
        end
        checkOutput("toggle_first_line", 32'(first_ls), 32'd1599);
        checkOutput("toggle_line_period", 32'(second_ls - first_ls), 32'd1600);
        checkOutput("strobe_width", 32'(doubles), 32'd0);

        $display("[TB] small raster frame timing");
        applyStimulus(1'b0, 1'b1);
        fs1 = -1; fs2 = -1; vb1 = -1; vb2 = -1;
        vs_low = 0; de_count = 0;
        for (int i = 1; i <= 400; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (frame_start_s) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
            if (vblank_start_s) begin
                if (vb1 < 0) vb1 = i;
                else if (vb2 < 0) vb2 = i;
            end
            if (i <= 195) begin
                if (!vsync_s) vs_low++;
                if (display_on_s) de_count++;
            end
        end
        checkOutput("small_first_frame", 32'(fs1), 32'd195);
        checkOutput("small_frame_period", 32'(fs2 - fs1), 32'd195);
        checkOutput("small_first_vblank", 32'(vb1), 32'd90);
        checkOutput("small_vblank_after_frame", 32'(vb2 - fs1), 32'd90);
        checkOutput("small_vsync_low", 32'(vs_low), 32'd30);
        checkOutput("small_display_count", 32'(de_count), 32'd48);

        $display("[TB] reset during sync");
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 146; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_reset_pos", 32'({hpos_s, vpos_s}), 32'({10'd11, 10'd9}));
        checkOutput("pre_reset_syncs", 32'({hsync_s, vsync_s}), 32'b00);
        applyStimulus(1'b0, 1'b1);
        checkOutput("mid_reset_pos", 32'({hpos_s, vpos_s}), 32'd0);
        checkOutput("mid_reset_syncs", 32'({hsync_s, vsync_s}), 32'b11);
        checkOutput("mid_reset_display_on", 32'(display_on_s), 32'd1);
        checkOutput("mid_reset_strobes",
                    32'({line_start_s, frame_start_s, vblank_start_s}), 32'd0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("reset_pix_off_pos", 32'({hpos_s, vpos_s}), 32'd0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
